// File: rtl/buffer_router_fifo.sv
// First-word-fall-through FIFO for a router input buffer: circular array with
// registered occupancy count, almost-full threshold and sticky overflow/underflow flags.
module buffer_router_fifo #(
    parameter int DATA_SIZE = 64,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Re,
    input  logic                   We,
    input  logic [DATA_SIZE-1:0]   data_in,
    input  logic                   err_clr,
    output logic [DATA_SIZE-1:0]   data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_do, rd_do;

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_CNT);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign data_out    = empty ? '0 : mem[rd_ptr_q];

    // A write into a full FIFO is allowed only when a pop frees the head slot
    // in the same cycle; a read against an empty FIFO is always ignored.
    always_comb begin
        wr_do       = We && (!full || Re);
        rd_do       = Re && !empty;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_do) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_do) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({wr_do, rd_do})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear so a coincident error is never lost.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (We && full && !Re) begin
            overflow_d = 1'b1;
        end
        if (Re && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; an emptied count already masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_buffer_router_fifo.sv
// Directed bench for buffer_router_fifo: stimulus queues expected pop data,
// a negedge monitor compares every accepted read against that queue.
module tb_buffer_router_fifo;

    localparam int DW = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          Re, We, err_clr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, overflow, underflow;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q [$];

    buffer_router_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH), .AF_MARGIN(1)) dut (
        .clk(clk), .reset(reset), .Re(Re), .We(We), .data_in(data_in),
        .err_clr(err_clr), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, return at posedge+1.
    task automatic drive(input logic we, input logic re, input logic [DW-1:0] din,
                         input logic clr);
        We = we; Re = re; data_in = din; err_clr = clr;
        @(posedge clk); #1;
        We = 1'b0; Re = 1'b0; data_in = '0; err_clr = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] din);
        drive(1'b1, 1'b0, din, 1'b0);
    endtask

    task automatic pop(input logic [DW-1:0] expv);
        exp_q.push_back(expv);
        drive(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic push_pop(input logic [DW-1:0] din, input logic [DW-1:0] expv);
        exp_q.push_back(expv);
        drive(1'b1, 1'b1, din, 1'b0);
    endtask

    // Monitor: an accepted read shows its data on data_out during the cycle.
    always @(negedge clk) begin
        if (reset && Re && !empty) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no read", data_out);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h", data_out, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; Re = 1'b0; We = 1'b0; err_clr = 1'b0; data_in = '0;
        #3;
        check("rst_count",  DW'(count), 0);
        check("rst_empty",  DW'(empty), 1);
        check("rst_full",   DW'(full), 0);
        check("rst_af",     DW'(almost_full), 0);
        check("rst_dout",   data_out, 0);
        check("rst_flags",  DW'({overflow, underflow}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Fill to full
        push(64'hA1);
        check("fill1_count", DW'(count), 1);
        check("fill1_dout",  data_out, 64'hA1);
        check("fill1_af",    DW'(almost_full), 0);
        push(64'hA2);
        check("fill2_count", DW'(count), 2);
        push(64'hA3);
        check("fill3_count", DW'(count), 3);
        check("fill3_af",    DW'(almost_full), 1);
        check("fill3_full",  DW'(full), 0);
        push(64'hA4);
        check("fill4_count", DW'(count), 4);
        check("fill4_full",  DW'(full), 1);
        check("fill4_dout",  data_out, 64'hA1);

        // Dropped write into full FIFO
        push(64'hFF);
        check("ovf_flag",  DW'(overflow), 1);
        check("ovf_count", DW'(count), 4);
        check("ovf_dout",  data_out, 64'hA1);

        // Simultaneous push/pop while full
        push_pop(64'hB5, 64'hA1);
        check("fullrw_count", DW'(count), 4);
        check("fullrw_dout",  data_out, 64'hA2);
        pop(64'hA2);
        pop(64'hA3);
        pop(64'hA4);
        pop(64'hB5);
        check("drain_count", DW'(count), 0);
        check("drain_empty", DW'(empty), 1);
        check("drain_dout",  data_out, 0);
        check("ovf_sticky",  DW'(overflow), 1);
        drive(1'b0, 1'b0, '0, 1'b1);
        check("ovf_clr",     DW'(overflow), 0);

        // Push/pop on empty: write only, underflow flagged
        drive(1'b1, 1'b1, 64'hC7, 1'b0);
        check("udf_count", DW'(count), 1);
        check("udf_dout",  data_out, 64'hC7);
        check("udf_flag",  DW'(underflow), 1);
        drive(1'b0, 1'b0, '0, 1'b1);
        check("udf_clr",   DW'(underflow), 0);
        pop(64'hC7);
        drive(1'b0, 1'b1, '0, 1'b1);
        check("udf_set_wins_clr", DW'(underflow), 1);
        drive(1'b0, 1'b0, '0, 1'b1);
        check("udf_clr2",  DW'(underflow), 0);

        // Ten streamed pairs wrap both pointers repeatedly
        push(64'd0);
        for (int i = 1; i < 10; i++) begin
            push_pop(DW'(i), DW'(i - 1));
            check("stream_count", DW'(count), 1);
        end
        pop(64'd9);
        check("stream_end_count", DW'(count), 0);

        // Asynchronous reset mid-cycle with three entries and flags set
        drive(1'b0, 1'b1, '0, 1'b0);
        push(64'hD1);
        push(64'hD2);
        push(64'hD3);
        check("pre_rst_count", DW'(count), 3);
        check("pre_rst_udf",   DW'(underflow), 1);
        #2; reset = 1'b0; #1;
        check("arst_count", DW'(count), 0);
        check("arst_empty", DW'(empty), 1);
        check("arst_dout",  data_out, 0);
        check("arst_udf",   DW'(underflow), 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        push(64'hE1);
        check("post_rst_count", DW'(count), 1);
        check("post_rst_dout",  data_out, 64'hE1);
        pop(64'hE1);
        check("post_rst_empty", DW'(empty), 1);
        check("post_rst_dout0", data_out, 0);

        @(posedge clk); #1;
        check("scoreboard_left", DW'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
